// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with a registered carry between slices and valid/ready handshakes on both sides.
module seq_chunk_adder #(
  parameter int WIDTH = 100,
  parameter int CHUNK = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK:0]   w_slice_sum;
  logic             w_msb_cin;
  logic             w_last;
  logic             w_accept;

  // Handshake outputs decode only the state register, so neither in_valid nor
  // out_ready has a combinational path to the flags.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_a_slice   = r_a[int'(r_idx) * CHUNK +: CHUNK];
  assign w_b_slice   = r_b[int'(r_idx) * CHUNK +: CHUNK];
  assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + (CHUNK + 1)'(r_carry);
  // Carry into the top bit recovered from sum ^ a ^ b at that bit position.
  assign w_msb_cin   = w_slice_sum[CHUNK-1] ^ w_a_slice[CHUNK-1] ^ w_b_slice[CHUNK-1];

  always_comb begin
    // NOTE: default assigned first so every path writes w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      r_state <= w_next_state;
    end
  end

  // Subtraction is A + ~B + ~Cin, so Cout=1 means no borrow in sub mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= Sub ? ~B : B;
      r_carry <= Sub ? ~Cin : Cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_slice_sum[CHUNK-1:0];
      r_carry <= w_slice_sum[CHUNK];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_slice_sum[CHUNK];
        r_ovf  <= w_msb_cin ^ w_slice_sum[CHUNK];
      end
    end
  end

endmodule
